// File: rtl/fifo_stream_reader.sv
// Read-side master for sync_fifo: turns the FIFO's rd_en/empty interface with RD_LATENCY
// read data into a registered valid/ready stream, prefetching into a small circular buffer.
module fifo_stream_reader #(
    parameter int WIDTH      = 8,
    parameter int RD_LATENCY = 1
) (
    input  logic                               i_clk,
    input  logic                               i_rst_n,
    output logic                               o_fifo_rd_en,
    input  logic                               i_fifo_empty,
    input  logic [WIDTH-1:0]                   i_fifo_rd_data,
    output logic                               o_m_valid,
    input  logic                               i_m_ready,
    output logic [WIDTH-1:0]                   o_m_data,
    output logic [$clog2(RD_LATENCY+3)-1:0]    o_buf_count
);

    localparam int BUF_DEPTH = RD_LATENCY + 2;
    localparam int CW        = $clog2(BUF_DEPTH + 1);
    localparam int PW        = $clog2(BUF_DEPTH);

    typedef logic [PW-1:0] ptr_t;

    logic [RD_LATENCY-1:0] pipe_q, pipe_d;
    logic [WIDTH-1:0]      buf_q [BUF_DEPTH];
    ptr_t                  head_q, head_d;
    ptr_t                  tail_q, tail_d;
    logic [CW-1:0]         count_q, count_d;
    logic [CW-1:0]         inflight;
    logic [CW:0]           occupancy;
    logic                  valid_q;
    logic [WIDTH-1:0]      data_q, data_d;
    logic                  rd_en, capture, pop;

    function automatic ptr_t ptr_inc(input ptr_t p);
        return (p == ptr_t'(BUF_DEPTH - 1)) ? '0 : p + ptr_t'(1);
    endfunction

    // Issue only needs registered state and the empty flag; ready never reaches rd_en.
    always_comb begin
        inflight = '0;
        for (int unsigned i = 0; i < RD_LATENCY; i++) begin
            inflight = inflight + CW'(pipe_q[i]);
        end
        occupancy = {1'b0, count_q} + {1'b0, inflight};
        rd_en     = i_rst_n && !i_fifo_empty && (occupancy < (CW+1)'(BUF_DEPTH));
    end

    assign capture = pipe_q[RD_LATENCY-1];
    assign pop     = valid_q && i_m_ready;

    always_comb begin
        pipe_d[0] = rd_en;
        for (int unsigned i = 1; i < RD_LATENCY; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end

        head_d  = pop     ? ptr_inc(head_q) : head_q;
        tail_d  = capture ? ptr_inc(tail_q) : tail_q;
        count_d = count_q;
        if (capture && !pop) begin
            count_d = count_q + CW'(1);
        end else if (!capture && pop) begin
            count_d = count_q - CW'(1);
        end

        // Output data is registered, so look ahead: a word landing at the new head this
        // edge bypasses the array.
        data_d = data_q;
        if (count_d != '0) begin
            data_d = (capture && (head_d == tail_q)) ? i_fifo_rd_data : buf_q[head_d];
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pipe_q  <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            pipe_q  <= pipe_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            valid_q <= (count_d != '0);
            data_q  <= data_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (capture) begin
            buf_q[tail_q] <= i_fifo_rd_data;
        end
    end

    assign o_fifo_rd_en = rd_en;
    assign o_m_valid    = valid_q;
    assign o_m_data     = data_q;
    assign o_buf_count  = count_q;

    a_no_overflow: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        !(capture && !pop && (count_q == CW'(BUF_DEPTH))));

endmodule
